// File: rtl/pipo_pkg.sv
// Shared defaults and helpers for the pipo_fifo buffer.
package pipo_pkg;

  localparam int PIPO_WIDTH = 32;
  localparam int PIPO_DEPTH = 4;

  // Occupancy runs 0..depth inclusive, so it needs one value more than the pointers.
  function automatic int pipo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipo_fifo_mem.sv
// DEPTH x WIDTH storage for pipo_fifo: one synchronous write port and one
// asynchronous read port. The array is deliberately not reset.
module pipo_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipo_fifo.sv
// Parallel-in/parallel-out FIFO with ready/valid flow control and a legacy
// per-write done pulse. Define PIPO_FIFO_OVF_EN to add the sticky overflow flag.
module pipo_fifo
  import pipo_pkg::*;
#(
  parameter int WIDTH = PIPO_WIDTH,
  parameter int DEPTH = PIPO_DEPTH,
  parameter int CW    = pipo_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load,
  output logic             ready,
  output logic [WIDTH-1:0] d_out,
  output logic             valid,
  input  logic             take,
  output logic             done,
`ifdef PIPO_FIFO_OVF_EN
  output logic             overflow,
  input  logic             ovf_clr,
`endif
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_done;
  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_rdata;

  // Handshake: a write transfers on a rising edge where load && ready, a pop
  // where take && valid. ready/valid depend only on the registered count, so a
  // pop in the same cycle never makes room for a write into a full buffer.
  assign ready = (r_count != FULL_CNT);
  assign valid = (r_count != '0);
  assign w_wr  = load & ready;
  assign w_rd  = take & valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_wr;
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  pipo_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_wr),
    .i_waddr(r_wptr),
    .i_wdata(d_in),
    .i_raddr(r_rptr),
    .o_rdata(w_rdata)
  );

  assign d_out = valid ? w_rdata : '0;
  assign done  = r_done;
  assign count = r_count;

`ifdef PIPO_FIFO_OVF_EN
  logic r_ovf;

  // Set wins over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (load && !ready) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_pipo_fifo.sv
// Self-checking bench for pipo_fifo: queue-based reference model, per-cycle
// compare process, directed scenarios and a randomized phase.
module tb_pipo_fifo;
  import pipo_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = pipo_cnt_w(D);

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  d_in;
  logic          load;
  logic          take;
  logic          ovf_clr;
  logic          ready;
  logic          valid;
  logic          done;
  logic [W-1:0]  d_out;
  logic [CW-1:0] count;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  pipo_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d_in    (d_in),
    .load    (load),
    .ready   (ready),
    .d_out   (d_out),
    .valid   (valid),
    .take    (take),
    .done    (done),
`ifdef PIPO_FIFO_OVF_EN
    .overflow(overflow),
    .ovf_clr (ovf_clr),
`endif
    .count   (count)
  );

`ifndef PIPO_FIFO_OVF_EN
  assign overflow = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: a plain queue of words in arrival order
  logic [W-1:0] exp_q[$];
  bit           exp_done = 1'b0;
  bit           exp_ovf  = 1'b0;

  always @(negedge reset_n) begin
    exp_q.delete();
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_done = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      bit full_now;
      bit wr;
      bit rd;
      full_now = (exp_q.size() == D);
      wr = load && !full_now;
      rd = take && (exp_q.size() > 0);
`ifdef PIPO_FIFO_OVF_EN
      if (load && full_now) exp_ovf = 1'b1;
      else if (ovf_clr)     exp_ovf = 1'b0;
`endif
      if (rd) void'(exp_q.pop_front());
      if (wr) exp_q.push_back(d_in);
      exp_done = wr;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every falling edge, DUT against the model
  always @(negedge clk) begin
    logic [W-1:0] e_dout;
    e_dout = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("valid", 64'(valid), 64'(exp_q.size() > 0));
    chk("ready", 64'(ready), 64'(exp_q.size() < D));
    chk("d_out", 64'(d_out), 64'(e_dout));
    chk("done",  64'(done),  64'(exp_done));
`ifdef PIPO_FIFO_OVF_EN
    chk("overflow", 64'(overflow), 64'(exp_ovf));
`endif
  end

  // driver: hold inputs for one rising edge, return 1 time unit after it
  task automatic cyc(input logic l, input logic t, input logic [W-1:0] d, input logic c = 1'b0);
    load    = l;
    take    = t;
    d_in    = d;
    ovf_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    load = 1'b0; take = 1'b0; d_in = '0; ovf_clr = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_dout",  64'(d_out), 64'd0);
    chk("rst_done",  64'(done),  64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // single write, visible one cycle later with done
    cyc(1, 0, 32'hA5A5_0001);
    chk("w1_valid", 64'(valid), 64'd1);
    chk("w1_dout",  64'(d_out), 64'hA5A5_0001);
    chk("w1_done",  64'(done),  64'd1);
    chk("w1_count", 64'(count), 64'd1);
    cyc(0, 1, '0);
    chk("w1_done_off", 64'(done),  64'd0);
    chk("w1_empty",    64'(count), 64'd0);

    // fill to DEPTH, then a dropped write
    for (int i = 0; i < D; i++) cyc(1, 0, 32'h1000_0000 + i);
    chk("full_ready", 64'(ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    cyc(1, 0, 32'hDEAD_BEEF);
    chk("drop_count", 64'(count), 64'd4);
    chk("drop_head",  64'(d_out), 64'h1000_0000);
`ifdef PIPO_FIFO_OVF_EN
    chk("ovf_set", 64'(overflow), 64'd1);
    cyc(0, 0, '0, 1'b1);
    chk("ovf_clr", 64'(overflow), 64'd0);
`endif

    // load + take while full: pop only
    cyc(1, 1, 32'hBAD0_0000);
    chk("lt_full_count", 64'(count), 64'd3);
    chk("lt_full_ready", 64'(ready), 64'd1);
    chk("lt_full_head",  64'(d_out), 64'h1000_0001);

    // steady load+take at count 2 with ascending data
    cyc(0, 1, '0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 32'h2000_0000 + i);
      chk("steady_count", 64'(count), 64'd2);
    end
    chk("steady_head", 64'(d_out), 64'h2000_0008);

    // drain, then take while empty
    cyc(0, 1, '0);
    cyc(0, 1, '0);
    cyc(0, 1, '0);
    chk("empty_count", 64'(count), 64'd0);
    chk("empty_dout",  64'(d_out), 64'd0);
    chk("empty_valid", 64'(valid), 64'd0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
          1'($urandom_range(0, 7) == 0));
    end
    while (count != 0) cyc(0, 1, '0);

    // fill 3 words, reset mid-cycle
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h3000_0000 + i);
    cyc(1, 0, 32'hDEAD_0000);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_valid", 64'(valid), 64'd0);
    chk("mrst_done",  64'(done),  64'd0);
    chk("mrst_dout",  64'(d_out), 64'd0);
    chk("mrst_ovf",   64'(overflow), 64'd0);
    load = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1, 0, 32'h4444_5555);
    chk("post_rst_dout",  64'(d_out), 64'h4444_5555);
    chk("post_rst_count", 64'(count), 64'd1);
    cyc(0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
